// File: rtl/tpu_out_writer_pkg.sv
// Shared sizes and FSM encoding for the GBUFF_OUT write side.
// No logic; constants and types only.
// Not applicable (no handshake).
package tpu_out_writer_pkg;

    localparam int TPU_ARRAY     = 4;
    localparam int TPU_DATA_SIZE = 8;
    localparam int TPU_ACC_SIZE  = 16;
    localparam int TPU_DIM_W     = 4;
    localparam int TPU_ADDR_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/tpu_out_pack.sv
// Truncates each accumulator lane to DATA_SIZE bits and zeroes lanes beyond col_b.
// Combinational, zero latency.
// No backpressure; pure function of its inputs.
module tpu_out_pack
    import tpu_out_writer_pkg::*;
#(
    parameter int ARRAY     = TPU_ARRAY,
    parameter int DATA_SIZE = TPU_DATA_SIZE,
    parameter int ACC_SIZE  = TPU_ACC_SIZE,
    parameter int DIM_W     = TPU_DIM_W
) (
    input  logic [ARRAY*ACC_SIZE-1:0]  res_data,
    input  logic [DIM_W-1:0]           tile,
    input  logic [DIM_W-1:0]           col_b,
    output logic [ARRAY*DATA_SIZE-1:0] word
);

    localparam int COL_W = DIM_W + $clog2(ARRAY);
    localparam int HI_W  = ACC_SIZE - DATA_SIZE;

    logic [COL_W-1:0]      col;
    logic [ARRAY*HI_W-1:0] hi_unused;

    always_comb begin
        word      = '0;
        col       = '0;
        hi_unused = '0;
        for (int c = 0; c < ARRAY; c++) begin
            col = COL_W'(tile) * COL_W'(ARRAY) + COL_W'(c);
            // Upper accumulator bits are discarded: wrap, not saturate.
            hi_unused[c*HI_W +: HI_W] = res_data[c*ACC_SIZE+DATA_SIZE +: HI_W];
            if (col < COL_W'(col_b))
                word[c*DATA_SIZE +: DATA_SIZE] = res_data[c*ACC_SIZE +: DATA_SIZE];
        end
    end

endmodule

// File: rtl/tpu_out_writer.sv
// Packs systolic-array result rows into GBUFF_OUT words in column-tile order; owns start/done.
// One cycle from accepted beat to wr_en; done follows the final wr_en by one cycle.
// res_ready is high throughout WRITE, so beats may arrive every cycle; no internal buffering.
module tpu_out_writer
    import tpu_out_writer_pkg::*;
#(
    parameter int ARRAY     = TPU_ARRAY,
    parameter int DATA_SIZE = TPU_DATA_SIZE,
    parameter int ACC_SIZE  = TPU_ACC_SIZE,
    parameter int DIM_W     = TPU_DIM_W,
    parameter int ADDR_W    = TPU_ADDR_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DIM_W-1:0]           row_a,
    input  logic [DIM_W-1:0]           col_b,
    input  logic                       res_valid,
    input  logic [ARRAY*ACC_SIZE-1:0]  res_data,
    output logic                       res_ready,
    output logic                       wr_en,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [ARRAY*DATA_SIZE-1:0] wr_data,
    output logic                       done
);

    wr_state_t state, state_nxt;

    logic                       start_q;
    logic                       start_edge;
    logic                       job_load;
    logic                       job_empty;
    logic                       beat;
    logic                       row_last;
    logic                       last_beat;
    logic [DIM_W-1:0]           row_a_q;
    logic [DIM_W-1:0]           col_b_q;
    logic [DIM_W-1:0]           n_tiles;
    logic [DIM_W-1:0]           row;
    logic [DIM_W-1:0]           tile;
    logic [DIM_W:0]             col_round;
    logic [ADDR_W-1:0]          addr_nxt;
    logic [ARRAY*DATA_SIZE-1:0] word_nxt;

    assign start_edge = start & ~start_q;
    assign job_empty  = (row_a == '0) || (col_b == '0);
    assign res_ready  = (state == ST_WRITE);
    assign beat       = res_valid & res_ready;
    assign row_last   = (row == row_a_q - DIM_W'(1));
    assign last_beat  = beat && row_last && (tile == n_tiles - DIM_W'(1));
    // A start edge is honoured from IDLE or DONE only; mid-job edges are dropped.
    assign job_load   = start_edge && (state != ST_WRITE);
    assign col_round  = {1'b0, col_b} + (DIM_W+1)'(ARRAY - 1);
    assign addr_nxt   = ADDR_W'(tile) * ADDR_W'(row_a_q) + ADDR_W'(row);

    tpu_out_pack #(
        .ARRAY     (ARRAY),
        .DATA_SIZE (DATA_SIZE),
        .ACC_SIZE  (ACC_SIZE),
        .DIM_W     (DIM_W)
    ) u_pack (
        .res_data (res_data),
        .tile     (tile),
        .col_b    (col_b_q),
        .word     (word_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_edge)
                    state_nxt = job_empty ? ST_DONE : ST_WRITE;
            end
            ST_WRITE: begin
                if (last_beat)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            row_a_q <= '0;
            col_b_q <= '0;
            n_tiles <= '0;
            row     <= '0;
            tile    <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            done    <= 1'b0;
        end else begin
            start_q <= start;
            wr_en   <= beat;
            if (job_load) begin
                row_a_q <= row_a;
                col_b_q <= col_b;
                n_tiles <= DIM_W'(col_round / (DIM_W+1)'(ARRAY));
                row     <= '0;
                tile    <= '0;
                done    <= 1'b0;
            end else if (state == ST_DONE) begin
                done    <= 1'b1;
            end
            if (beat) begin
                wr_addr <= addr_nxt;
                wr_data <= word_nxt;
                if (row_last) begin
                    row  <= '0;
                    tile <= tile + DIM_W'(1);
                end else begin
                    row  <= row + DIM_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tpu_out_writer.sv
// Randomized scoreboard bench for tpu_out_writer: driver pushes expected writes, monitor pops on wr_en.
module tb_tpu_out_writer;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  row_a;
    logic [3:0]  col_b;
    logic        res_valid;
    logic [63:0] res_data;
    logic        res_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    always #5 clk = ~clk;

    tpu_out_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_a     (row_a),
        .col_b     (col_b),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: column j of C lands in byte (j mod 4) of the tile (j div 4) word; beyond col_b is 0.
    function automatic logic [31:0] exp_word(input logic [63:0] d, input int t, input int cb);
        logic [31:0] w;
        w = '0;
        for (int c = 0; c < 4; c++)
            if (t * 4 + c < cb) w[c*8 +: 8] = d[c*16 +: 8];
        return w;
    endfunction

    function automatic logic [63:0] make_lanes(input int mode, input int idx);
        logic [63:0] d;
        for (int c = 0; c < 4; c++) begin
            case (mode)
                1:       d[c*16 +: 16] = 16'(17 * (c + 1) + 256 * idx);
                2:       d[c*16 +: 16] = 16'h01FE;
                default: d[c*16 +: 16] = 16'($urandom);
            endcase
        end
        return d;
    endfunction

    // Monitor: every write strobe must match the oldest outstanding expectation.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wr_en", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                end
            end
        end
    end

    task automatic issue_beat(input logic [63:0] d, input int addr, input logic [31:0] w,
                              input bit gaps, output bit ok);
        int waited;
        wr_t e;
        ok = 1'b1;
        waited = 0;
        while (gaps && waited < 3 && $urandom_range(0, 1) == 0) begin
            res_valid = 1'b0;
            @(negedge clk);
            waited++;
        end
        res_data  = d;
        res_valid = 1'b1;
        waited = 0;
        while (res_ready !== 1'b1) begin
            if (waited > 20) begin
                check("res_ready_timeout", 64'(res_ready), 1);
                res_valid = 1'b0;
                ok = 1'b0;
                return;
            end
            @(negedge clk);
            waited++;
        end
        e.addr = 8'(addr);
        e.data = w;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic run_job(input int ra, input int cb, input int mode, input bit gaps,
                           input bit hold, input bit poke, input int abort_after);
        int nt, n, idx;
        bit ok;
        logic [63:0] d;
        start = 1'b0;
        @(negedge clk);
        row_a = 4'(ra);
        col_b = 4'(cb);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("done_cleared_on_start", 64'(done), 0);
        if (ra == 0 || cb == 0) begin
            check("empty_res_ready", 64'(res_ready), 0);
            @(negedge clk);
            check("empty_done", 64'(done), 1);
            return;
        end
        row_a = 4'($urandom);
        col_b = 4'($urandom);
        nt = (cb + 3) / 4;
        n = 0;
        for (int t = 0; t < nt; t++) begin
            for (int r = 0; r < ra; r++) begin
                idx = t * ra + r;
                d = make_lanes(mode, idx);
                issue_beat(d, idx, exp_word(d, t, cb), gaps, ok);
                if (!ok) return;
                n++;
                if (n == abort_after) begin
                    #2;
                    rst = 1'b0;
                    res_valid = 1'b0;
                    #1;
                    check("abort_res_ready", 64'(res_ready), 0);
                    check("abort_wr_en", 64'(wr_en), 0);
                    check("abort_done", 64'(done), 0);
                    exp_q.delete();
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
                @(negedge clk);
                if (poke) start = (n == 1);
            end
        end
        res_valid = 1'b0;
        start = hold;
        check("final_wr_en", 64'(wr_en), 1);
        check("done_before_final", 64'(done), 0);
        check("ready_drop_after_last", 64'(res_ready), 0);
        @(negedge clk);
        check("done_after_final", 64'(done), 1);
        check("wr_en_after_final", 64'(wr_en), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ra, cb;
        bit pk;
        rst = 1'b0;
        start = 1'b0;
        row_a = '0;
        col_b = '0;
        res_valid = 1'b0;
        res_data = '0;
        repeat (3) @(negedge clk);
        check("reset_res_ready", 64'(res_ready), 0);
        check("reset_wr_en", 64'(wr_en), 0);
        check("reset_done", 64'(done), 0);
        check("reset_wr_addr", 64'(wr_addr), 0);
        check("reset_wr_data", 64'(wr_data), 0);
        rst = 1'b1;

        run_job(4, 4, 1, 0, 0, 0, 0);
        run_job(2, 3, 2, 0, 0, 0, 0);
        run_job(3, 6, 0, 0, 0, 0, 0);
        run_job(4, 4, 1, 1, 0, 0, 0);
        run_job(2, 5, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("held_start_done", 64'(done), 1);
            check("held_start_idle", 64'(res_ready), 0);
        end
        run_job(0, 4, 0, 0, 0, 0, 0);
        run_job(3, 0, 0, 0, 0, 0, 0);
        run_job(4, 4, 1, 0, 0, 0, 2);
        run_job(4, 4, 0, 0, 0, 0, 0);
        run_job(3, 7, 0, 1, 0, 1, 0);
        run_job(15, 15, 0, 0, 0, 0, 0);

        for (int j = 0; j < 30; j++) begin
            ra = $urandom_range(1, 6);
            cb = $urandom_range(1, 12);
            pk = (ra * ((cb + 3) / 4) >= 3) && ($urandom_range(0, 1) == 1);
            run_job(ra, cb, 0, 1'($urandom_range(0, 1)), 0, pk, 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
